// File: rtl/rv32_data_mem_bus.sv
// Data-side slave for rv32_core: word RAM plus a 4 KiB MMIO page holding a buffered
// UART transmitter (8N1), a status register and a free-running cycle counter.
module rv32_data_mem_bus #(
  parameter int unsigned RAM_DEPTH_WORDS = 4096,
  parameter logic [31:0] MMIO_BASE       = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned CLKS_PER_BIT    = 868
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [3:0]  memory_write_enable_i,
  input  logic [31:0] memory_data_address_i,
  input  logic [31:0] memory_write_data_i,
  output logic [31:0] read_data_o,
  output logic        uart_tx_o,
  output logic        uart_busy_o
);

  localparam int unsigned RamAw  = $clog2(RAM_DEPTH_WORDS);
  localparam int unsigned FifoAw = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW   = FifoAw + 1;
  localparam int unsigned BaudW  = $clog2(CLKS_PER_BIT);

  localparam logic [CntW-1:0]  FifoFull = CntW'(FIFO_DEPTH);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

  localparam logic [11:0] OffTxData = 12'h000;
  localparam logic [11:0] OffStatus = 12'h004;
  localparam logic [11:0] OffCycles = 12'h008;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} tx_state_e;

  // Address decode
  logic             mmio_sel;
  logic [11:0]      offset;
  logic [RamAw-1:0] ram_idx;

  assign mmio_sel = (memory_data_address_i[31:12] == MMIO_BASE[31:12]);
  assign offset   = memory_data_address_i[11:0];
  assign ram_idx  = memory_data_address_i[RamAw+1:2];

  // Word RAM, not reset; byte lanes written independently
  logic [31:0] ram_q [RAM_DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (!mmio_sel) begin
      if (memory_write_enable_i[0]) ram_q[ram_idx][7:0]   <= memory_write_data_i[7:0];
      if (memory_write_enable_i[1]) ram_q[ram_idx][15:8]  <= memory_write_data_i[15:8];
      if (memory_write_enable_i[2]) ram_q[ram_idx][23:16] <= memory_write_data_i[23:16];
      if (memory_write_enable_i[3]) ram_q[ram_idx][31:24] <= memory_write_data_i[31:24];
    end
  end

  // MMIO state
  logic [7:0]        fifo_q [FIFO_DEPTH];
  logic [FifoAw-1:0] wr_ptr_q, wr_ptr_d;
  logic [FifoAw-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [31:0]       cycle_q, cycle_d;

  tx_state_e         state_q, state_d;
  logic [BaudW-1:0]  baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;

  logic push_req, push, pop, clr_ovf;
  logic fifo_full, fifo_empty, tx_active, busy;

  assign fifo_full  = (count_q == FifoFull);
  assign fifo_empty = (count_q == '0);
  assign tx_active  = (state_q != StIdle);
  assign busy       = tx_active | ~fifo_empty;

  assign push_req = mmio_sel && (offset == OffTxData) && memory_write_enable_i[0];
  // A push into a full FIFO is dropped even if a pop frees a slot this cycle
  assign push     = push_req && !fifo_full;
  assign pop      = (state_q == StIdle) && !fifo_empty;
  assign clr_ovf  = mmio_sel && (offset == OffStatus) && memory_write_enable_i[0] &&
                    memory_write_data_i[4];

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= memory_write_data_i[7:0];
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + FifoAw'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + FifoAw'(1) : rd_ptr_q;
    count_d    = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    overflow_d = overflow_q;
    if (clr_ovf)             overflow_d = 1'b0;
    if (push_req && fifo_full) overflow_d = 1'b1;
    cycle_d    = cycle_q + 32'd1;
  end

  // Transmit FSM; tx_d is computed from the next state so the line is registered
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (pop) begin
          state_d = StStart;
          shift_d = fifo_q[rd_ptr_q];
          baud_d  = BaudLast;
          tx_d    = 1'b0;
        end
      end
      StStart: begin
        if (baud_q == '0) begin
          state_d   = StData;
          baud_d    = BaudLast;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end else begin
          baud_d = baud_q - BaudW'(1);
        end
      end
      StData: begin
        if (baud_q == '0) begin
          baud_d = BaudLast;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          baud_d = baud_q - BaudW'(1);
        end
      end
      StStop: begin
        if (baud_q == '0) begin
          state_d = StIdle;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q - BaudW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      cycle_q    <= '0;
      state_q    <= StIdle;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      cycle_q    <= cycle_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

  // Combinational read path; MMIO reads have no side effects
  always_comb begin
    read_data_o = '0;
    if (mmio_sel) begin
      case (offset)
        OffStatus: read_data_o = {27'b0, overflow_q, busy, tx_active, fifo_empty, fifo_full};
        OffCycles: read_data_o = cycle_q;
        default:   read_data_o = '0;
      endcase
    end else begin
      read_data_o = ram_q[ram_idx];
    end
  end

  assign uart_tx_o   = tx_q;
  assign uart_busy_o = busy;

endmodule

// File: tb/tb_rv32_data_mem_bus.sv
// Randomised self-checking bench for rv32_data_mem_bus with a small RAM, 4-entry FIFO
// and 4 clocks per UART bit; a behavioural receiver decodes the serial line.
module tb_rv32_data_mem_bus;

  localparam int unsigned Cpb      = 4;
  localparam int unsigned Depth    = 4;
  localparam int unsigned RamDepth = 256;
  localparam logic [31:0] MmioBase = 32'h1000_0000;
  localparam logic [31:0] AStatus  = MmioBase + 32'h4;
  localparam logic [31:0] ACycles  = MmioBase + 32'h8;
  localparam int unsigned Period   = 10 * Cpb + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  we = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] read_data;
  logic        uart_tx;
  logic        uart_busy;

  int n_chk = 0;
  int n_pass = 0;
  int unsigned cyc = 0;

  logic [31:0] ram_m [RamDepth];
  logic [7:0]  rxq [$];
  int unsigned rx_start [$];
  bit          rx_frame_ok [$];

  rv32_data_mem_bus #(
    .RAM_DEPTH_WORDS(RamDepth),
    .MMIO_BASE      (MmioBase),
    .FIFO_DEPTH     (Depth),
    .CLKS_PER_BIT   (Cpb)
  ) dut (
    .clk_i                (clk),
    .rst_n_i              (rst_n),
    .memory_write_enable_i(we),
    .memory_data_address_i(addr),
    .memory_write_data_i  (wdata),
    .read_data_o          (read_data),
    .uart_tx_o            (uart_tx),
    .uart_busy_o          (uart_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] lanes);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = lanes[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    return r;
  endfunction

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    @(negedge clk);
    addr = a; wdata = d; we = w;
    @(negedge clk);
    we = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    we = '0; addr = a;
    #1;
    d = read_data;
  endtask

  // Waits for a start bit, samples mid-bit, checks start and stop levels
  task automatic rx_byte(input int unsigned tmo, output logic [7:0] b, output bit got,
                         output bit frame_ok, output int unsigned start_cyc);
    bit s_ok;
    got = 1'b0; frame_ok = 1'b0; b = '0; start_cyc = 0;
    for (int unsigned i = 0; i < tmo; i++) begin
      @(posedge clk); #1;
      if (uart_tx === 1'b0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) return;
    start_cyc = cyc;
    repeat (Cpb / 2) @(posedge clk);
    #1;
    s_ok = (uart_tx === 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (Cpb) @(posedge clk);
      #1;
      b[i] = uart_tx;
    end
    repeat (Cpb) @(posedge clk);
    #1;
    frame_ok = s_ok && (uart_tx === 1'b1);
  endtask

  task automatic rx_collect(input int max_frames);
    logic [7:0] b;
    bit got, ok;
    int unsigned sc;
    for (int i = 0; i < max_frames; i++) begin
      rx_byte(120, b, got, ok, sc);
      if (!got) break;
      rxq.push_back(b);
      rx_start.push_back(sc);
      rx_frame_ok.push_back(ok);
    end
  endtask

  task automatic test_reset;
    logic [31:0] d;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (uart_tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", uart_tx);
    else n_pass++;
    n_chk++;
    if (uart_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", uart_busy);
    else n_pass++;
    bus_read(AStatus, d);
    n_chk++;
    if (d !== 32'h2) $display("FAIL reset_status: got %h want %h", d, 32'h2);
    else n_pass++;
    bus_read(ACycles, d);
    n_chk++;
    if (d !== 32'h0) $display("FAIL reset_cycles: got %h want 0", d);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    addr = ACycles;
    #1;
    n_chk++;
    if (read_data !== 32'd10) $display("FAIL cycles_after_reset: got %0d want 10", read_data);
    else n_pass++;
  endtask

  task automatic test_ram;
    logic [31:0] d, v, alias_a;
    logic [3:0]  w;
    int unsigned idx;
    bus_write(32'h100, 32'h1122_3344, 4'hF);
    ram_m[32'h100 >> 2] = 32'h1122_3344;
    bus_write(32'h100, 32'hAA00_00BB, 4'b1001);
    ram_m[32'h100 >> 2] = merge(ram_m[32'h100 >> 2], 32'hAA00_00BB, 4'b1001);
    bus_read(32'h100, d);
    n_chk++;
    if (d !== ram_m[32'h100 >> 2]) $display("FAIL ram_lanes: got %h want %h", d, ram_m[64]);
    else n_pass++;
    bus_read(32'h100 + 4 * RamDepth, d);
    n_chk++;
    if (d !== ram_m[32'h100 >> 2]) $display("FAIL ram_wrap: got %h want %h", d, ram_m[64]);
    else n_pass++;
    // Write in flight: same-cycle read must show the old word
    @(negedge clk);
    addr = 32'h100; wdata = 32'hFFFF_FFFF; we = 4'hF;
    #1;
    n_chk++;
    if (read_data !== ram_m[64]) $display("FAIL ram_rdw: got %h want %h", read_data, ram_m[64]);
    else n_pass++;
    @(negedge clk);
    we = '0;
    ram_m[64] = 32'hFFFF_FFFF;
    #1;
    n_chk++;
    if (read_data !== ram_m[64]) $display("FAIL ram_after_w: got %h want %h", read_data, ram_m[64]);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      idx = $urandom_range(0, RamDepth - 1);
      v = $urandom;
      bus_write((idx << 2) + 4 * RamDepth * $urandom_range(0, 1000), v, 4'hF);
      ram_m[idx] = v;
      v = $urandom;
      w = 4'($urandom_range(0, 15));
      bus_write((idx << 2) + 4 * RamDepth * $urandom_range(0, 1000), v, w);
      ram_m[idx] = merge(ram_m[idx], v, w);
      alias_a = (idx << 2) + 4 * RamDepth * $urandom_range(0, 1000);
      bus_read(alias_a, d);
      n_chk++;
      if (d !== ram_m[idx]) $display("FAIL ram_rand[%0d]: @%h got %h want %h", i, alias_a, d,
                                     ram_m[idx]);
      else n_pass++;
    end
  endtask

  task automatic test_mmio_isolation;
    logic [31:0] d, v0, v1;
    int unsigned c0, c1;
    bus_write(32'h00C, 32'h0BAD_F00D, 4'hF);
    ram_m[3] = 32'h0BAD_F00D;
    bus_write(MmioBase + 32'hC, 32'hDEAD_BEEF, 4'hF);
    bus_read(MmioBase + 32'hC, d);
    n_chk++;
    if (d !== 32'h0) $display("FAIL mmio_unmapped: got %h want 0", d);
    else n_pass++;
    bus_read(32'h00C, d);
    n_chk++;
    if (d !== ram_m[3]) $display("FAIL mmio_no_ram_alias: got %h want %h", d, ram_m[3]);
    else n_pass++;
    bus_write(32'h0, 32'hDEAD_BEEF, 4'hF);
    ram_m[0] = 32'hDEAD_BEEF;
    bus_read(32'h0, d);
    n_chk++;
    if (d !== ram_m[0]) $display("FAIL ram_word0: got %h want %h", d, ram_m[0]);
    else n_pass++;
    bus_read(MmioBase, d);
    n_chk++;
    if (d !== 32'h0) $display("FAIL txdata_read: got %h want 0", d);
    else n_pass++;
    repeat (5) bus_read(AStatus, d);
    n_chk++;
    if (d !== 32'h2) $display("FAIL status_stable: got %h want 2", d);
    else n_pass++;
    // A write to CYCLES must not perturb the count
    bus_read(ACycles, v0);
    c0 = cyc;
    bus_write(ACycles, 32'h0, 4'hF);
    repeat (3) @(negedge clk);
    bus_read(ACycles, v1);
    c1 = cyc;
    n_chk++;
    if (v1 - v0 !== c1 - c0) $display("FAIL cycles_write_ignored: delta %0d want %0d", v1 - v0,
                                      c1 - c0);
    else n_pass++;
  endtask

  task automatic test_uart_frame;
    logic [7:0] byte_v;
    logic exp_tx, exp_busy;
    byte_v = 8'h55;
    @(negedge clk);
    addr = MmioBase; wdata = {24'h0, byte_v}; we = 4'h1;
    for (int k = 1; k <= 44; k++) begin
      @(posedge clk); #1;
      if (k == 1) we = '0;
      if (k < 2) exp_tx = 1'b1;
      else if (k < 2 + Cpb) exp_tx = 1'b0;
      else if (k < 2 + 9 * Cpb) exp_tx = byte_v[(k - 2 - Cpb) / Cpb];
      else exp_tx = 1'b1;
      exp_busy = (k < 2 + 10 * Cpb);
      n_chk++;
      if (uart_tx !== exp_tx || uart_busy !== exp_busy)
        $display("FAIL frame_cycle_%0d: tx/busy got %b/%b want %b/%b", k, uart_tx, uart_busy,
                 exp_tx, exp_busy);
      else n_pass++;
    end
  endtask

  task automatic test_fifo_overflow;
    logic [7:0] exp_q [$];
    logic [7:0] fifo_m [$];
    logic [31:0] d, st_full;
    bit ovf_m;
    // Model: first byte goes straight to the shifter, the rest fill the FIFO
    ovf_m = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      if (i == 1) exp_q.push_back(8'(i));
      else if (fifo_m.size() < Depth) fifo_m.push_back(8'(i));
      else ovf_m = 1'b1;
    end
    foreach (fifo_m[j]) exp_q.push_back(fifo_m[j]);
    rxq.delete(); rx_start.delete(); rx_frame_ok.delete();
    fork
      begin
        @(negedge clk);
        addr = MmioBase; we = 4'h1;
        for (int i = 1; i <= 6; i++) begin
          if (i > 1) @(negedge clk);
          wdata = 32'(i);
        end
        @(negedge clk);
        we = '0; addr = AStatus;
        #1;
        st_full = read_data;
      end
      rx_collect(6);
    join
    n_chk++;
    if (st_full !== {27'b0, ovf_m, 1'b1, 1'b1, 1'b0, 1'b1})
      $display("FAIL ovf_status: got %h want %h", st_full, {27'b0, ovf_m, 4'b1101});
    else n_pass++;
    n_chk++;
    if (rxq.size() != exp_q.size()) $display("FAIL ovf_frames: got %0d want %0d", rxq.size(),
                                             exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < rxq.size(); i++) begin
      n_chk++;
      if (rxq[i] !== exp_q[i] || !rx_frame_ok[i])
        $display("FAIL ovf_byte[%0d]: got %h framing %0d want %h", i, rxq[i], rx_frame_ok[i],
                 exp_q[i]);
      else n_pass++;
    end
    bus_read(AStatus, d);
    n_chk++;
    if (d !== 32'h12) $display("FAIL ovf_sticky: got %h want 12", d);
    else n_pass++;
    bus_write(AStatus, 32'h10, 4'h1);
    bus_read(AStatus, d);
    n_chk++;
    if (d !== 32'h2) $display("FAIL ovf_clear: got %h want 2", d);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes [$];
    int n;
    n = $urandom_range(2, Depth + 1);
    for (int i = 0; i < n; i++) bytes.push_back(8'($urandom));
    rxq.delete(); rx_start.delete(); rx_frame_ok.delete();
    fork
      begin
        @(negedge clk);
        addr = MmioBase; we = 4'h1;
        for (int i = 0; i < n; i++) begin
          if (i > 0) @(negedge clk);
          wdata = {24'h0, bytes[i]};
        end
        @(negedge clk);
        we = '0;
      end
      rx_collect(n);
    join
    n_chk++;
    if (rxq.size() != n) $display("FAIL b2b_frames: got %0d want %0d", rxq.size(), n);
    else n_pass++;
    for (int i = 0; i < n && i < rxq.size(); i++) begin
      n_chk++;
      if (rxq[i] !== bytes[i] || !rx_frame_ok[i])
        $display("FAIL b2b_byte[%0d]: got %h framing %0d want %h", i, rxq[i], rx_frame_ok[i],
                 bytes[i]);
      else n_pass++;
      if (i > 0) begin
        n_chk++;
        if (rx_start[i] - rx_start[i-1] != Period)
          $display("FAIL b2b_period[%0d]: got %0d want %0d", i, rx_start[i] - rx_start[i-1],
                   Period);
        else n_pass++;
      end
    end
  endtask

  task automatic test_cycle_wrap;
    @(negedge clk);
    we = '0; addr = ACycles;
    force dut.cycle_q = 32'hFFFF_FFFE;
    #1;
    release dut.cycle_q;
    #1;
    n_chk++;
    if (read_data !== 32'hFFFF_FFFE) $display("FAIL wrap_pre: got %h want fffffffe", read_data);
    else n_pass++;
    @(negedge clk); #1;
    n_chk++;
    if (read_data !== 32'hFFFF_FFFF) $display("FAIL wrap_max: got %h want ffffffff", read_data);
    else n_pass++;
    @(negedge clk); #1;
    n_chk++;
    if (read_data !== 32'h0) $display("FAIL wrap_zero: got %h want 0", read_data);
    else n_pass++;
  endtask

  task automatic test_reset_midframe;
    logic [7:0] b0;
    int lows;
    b0 = 8'($urandom) & 8'hF7;
    @(negedge clk);
    addr = MmioBase; we = 4'h1; wdata = {24'h0, b0};
    @(negedge clk); wdata = 32'($urandom) & 32'hFF;
    @(negedge clk); wdata = 32'($urandom) & 32'hFF;
    @(negedge clk); we = '0; addr = AStatus;
    // Now at cycle 3; data bit 3 of the first frame spans cycles 18..21
    repeat (16) @(negedge clk);
    #1;
    n_chk++;
    if (uart_tx !== b0[3] || read_data !== 32'h0C)
      $display("FAIL midframe_pre: tx %b status %h want %b/0c", uart_tx, read_data, b0[3]);
    else n_pass++;
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (uart_tx !== 1'b1 || uart_busy !== 1'b0 || read_data !== 32'h2)
      $display("FAIL midframe_reset: tx %b busy %b status %h want 1/0/2", uart_tx, uart_busy,
               read_data);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (uart_tx !== 1'b1 || uart_busy !== 1'b0) lows++;
    end
    n_chk++;
    if (lows != 0 || read_data !== 32'h2)
      $display("FAIL midframe_quiet: active cycles %0d status %h want 0/2", lows, read_data);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_ram();
    test_mmio_isolation();
    test_uart_frame();
    test_fifo_overflow();
    test_back_to_back();
    test_cycle_wrap();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
